// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int AF_LEVEL_DEF = 14;
    localparam int AE_LEVEL_DEF = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth - 1) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM, DEPTH x DATA_W, with a registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with level, threshold flags and read-valid strobe.
// Optional sticky overflow/underflow flags when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            dout_valid <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flags decode the registered count only.
    assign full         = (count == (ADDR_W+1)'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= (ADDR_W+1)'(AF_LEVEL));
    assign almost_empty = (count <= (ADDR_W+1)'(AE_LEVEL));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & full)   overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (rd & empty)  underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end
`endif

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & ~rst),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (default parameters) against a queue model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid, full, empty, almost_full, almost_empty;
    logic [4:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          err_clr = 1'b0;
    logic          overflow, underflow;
    bit            exp_ovf, exp_udf;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    bit            exp_valid;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DP));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_udf));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        int  pre;
        bit  w_acc, r_acc;
        wr = w; din = d; rd = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
`endif
        end else begin
            pre   = q.size();
            w_acc = w && (pre < DP);
            r_acc = r && (pre > 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (w && pre == DP) exp_ovf = 1'b1;
            else if (err_clr)   exp_ovf = 1'b0;
            if (r && pre == 0)  exp_udf = 1'b1;
            else if (err_clr)   exp_udf = 1'b0;
`endif
            exp_valid = r_acc;
            if (r_acc) exp_dout = q.pop_front();
            if (w_acc) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_count", 32'(count), 32'd0);

        // Fill with 0x01..0x10, then a dropped 17th write
        for (int i = 1; i <= DP; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == AF - 1) chk("af_below", 32'(almost_full), 32'd0);
            if (i == AF)     chk("af_rise", 32'(almost_full), 32'd1);
        end
        chk("full16", 32'(full), 32'd1);
        chk("count16", 32'(count), 32'd16);
        step(1'b1, 8'hFF, 1'b0);
        chk("count_after_ovf", 32'(count), 32'd16);

        // Drain; almost_empty rises when count reaches 2
        for (int i = 1; i <= DP; i++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_data", 32'(dout), 32'(i));
            chk("drain_valid", 32'(dout_valid), 32'd1);
            if (i == DP - AE - 1) chk("ae_above", 32'(almost_empty), 32'd0);
            if (i == DP - AE)     chk("ae_rise", 32'(almost_empty), 32'd1);
        end
        chk("drained_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("valid_drops", 32'(dout_valid), 32'd0);

        // Simultaneous wr&rd at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'h45 + i), 1'b1);
            chk("rw_count5", 32'(count), 32'd5);
            chk("rw_order", 32'(dout), 32'(8'h40 + i));
        end

        // wr&rd at full: only the read is taken
        while (q.size() < DP) step(1'b1, DW'($urandom), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("full_rw_count", 32'(count), 32'd15);

        // wr&rd at empty: only the write is taken
        while (q.size() > 0) step(1'b0, '0, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_valid", 32'(dout_valid), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("empty_rw_data", 32'(dout), 32'h5A);

        // Read on empty, then clear the sticky flag
        step(1'b0, '0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("udf_set", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        err_clr = 1'b0;
        chk("udf_clr", 32'(underflow), 32'd0);
`endif

        // Reset mid-burst with wr held high
        for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_word", 32'(dout), 32'hA5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            err_clr = ($urandom_range(0, 15) == 0);
`endif
            step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
